// File: rtl/execute_stage.sv
// Execute stage of the 5-stage pipeline: operand forwarding, 19-bit ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module execute_stage #(
  parameter int DATA_W = 19,
  parameter int PC_W   = 15,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              ALUSrcE,
  input  logic [1:0]        BranchE,
  input  logic              ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [PC_W-1:0]   PCE,
  input  logic [REG_W-1:0]  RDE,
  input  logic              Cant_ByteE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              StallM,
  input  logic              FlushE,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic              Cant_ByteM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_W-1:0]  RdM
);

  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M    = 2'b10;

  localparam logic [1:0] BR_BEQ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;
  localparam logic [1:0] BR_BLT = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [4:0] SHAMT_LIMIT = 5'(DATA_W);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        shamt;
  logic              branch_taken;

  // Encoding 11 falls back to the register file value, same as 00.
  always_comb begin
    src_a = RD1E;
    case (ForwardAE)
      FWD_RESULT_W: src_a = ResultW;
      FWD_ALU_M:    src_a = ALUResultM;
      default:      src_a = RD1E;
    endcase
  end

  always_comb begin
    fwd_b = RD2E;
    case (ForwardBE)
      FWD_RESULT_W: fwd_b = ResultW;
      FWD_ALU_M:    fwd_b = ALUResultM;
      default:      fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLL: alu_result = (shamt >= SHAMT_LIMIT) ? '0 : (src_a << shamt);
      ALU_SRL: alu_result = (shamt >= SHAMT_LIMIT) ? '0 : (src_a >> shamt);
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  // Branch compare ignores ALUSrcE: it always uses the forwarded register operand.
  always_comb begin
    branch_taken = 1'b0;
    case (BranchE)
      BR_BEQ:  branch_taken = (src_a == fwd_b);
      BR_BNE:  branch_taken = (src_a != fwd_b);
      BR_BLT:  branch_taken = ($signed(src_a) < $signed(fwd_b));
      default: branch_taken = 1'b0;
    endcase
  end

  assign PCSrcE    = ~FlushE & (JumpE | branch_taken);
  assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

  // Stall outranks flush so a squashed EX instruction cannot overwrite a held M stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
    end else if (!StallM) begin
      if (FlushE) begin
        RegWriteM  <= 1'b0;
        MemWriteM  <= 1'b0;
        ResultSrcM <= 1'b0;
        Cant_ByteM <= 1'b0;
        ALUResultM <= '0;
        WriteDataM <= '0;
        RdM        <= '0;
      end else begin
        RegWriteM  <= RegWriteE;
        MemWriteM  <= MemWriteE;
        ResultSrcM <= ResultSrcE;
        Cant_ByteM <= Cant_ByteE;
        ALUResultM <= alu_result;
        WriteDataM <= fwd_b;
        RdM        <= RDE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver pushes model expectations into
// queues and an independent monitor pops and compares them against the DUT.
module tb_execute_stage;

  localparam longint DATA_MOD = 524288;
  localparam longint PC_MOD   = 32768;

  typedef struct {
    logic        rst;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        alu_src;
    logic [1:0]  branch;
    logic        result_src;
    logic [2:0]  alu_ctl;
    logic [18:0] rd1;
    logic [18:0] rd2;
    logic [18:0] imm;
    logic [14:0] pc;
    logic [4:0]  rd;
    logic        cant_byte;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [18:0] result_w;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic        cant_byte;
    logic [18:0] alu_result;
    logic [18:0] write_data;
    logic [4:0]  rd;
  } mstate_t;

  typedef struct {
    logic        pcsrc;
    logic [14:0] target;
  } comb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE;
  logic [1:0]  BranchE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [18:0] RD1E, RD2E, ImmExtE, ResultW;
  logic [14:0] PCE;
  logic [4:0]  RDE;
  logic        StallM, FlushE;
  logic        PCSrcE;
  logic [14:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [18:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;

  int      tests_run = 0;
  int      failures  = 0;
  mstate_t model_m;
  comb_t   comb_q[$];
  mstate_t reg_q[$];

  execute_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .RDE(RDE),
    .Cant_ByteE(Cant_ByteE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .StallM(StallM), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Cant_ByteM(Cant_ByteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .RdM(RdM)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed_val(logic [18:0] v);
    longint u = v;
    return v[18] ? u - DATA_MOD : u;
  endfunction

  function automatic logic [18:0] pick(logic [1:0] sel, logic [18:0] reg_val,
                                       logic [18:0] wb_val, logic [18:0] mem_val);
    if (sel == 2'd1) return wb_val;
    if (sel == 2'd2) return mem_val;
    return reg_val;
  endfunction

  function automatic logic [18:0] model_alu(logic [2:0] op, logic [18:0] a, logic [18:0] b);
    longint ua = a;
    longint ub = b;
    longint sh = b % 32;
    longint r  = 0;
    case (op)
      3'd0: r = (ua + ub) % DATA_MOD;
      3'd1: r = (ua - ub + DATA_MOD) % DATA_MOD;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sh >= 19) ? 0 : (ua * (longint'(1) << sh)) % DATA_MOD;
      3'd6: r = (sh >= 19) ? 0 : ua / (longint'(1) << sh);
      default: r = (to_signed_val(a) < to_signed_val(b)) ? 1 : 0;
    endcase
    return 19'(r);
  endfunction

  function automatic stim_t nop_stim();
    stim_t s;
    s = '{rst: 1'b1, reg_write: 1'b0, mem_write: 1'b0, jump: 1'b0, alu_src: 1'b0,
          branch: 2'd0, result_src: 1'b0, alu_ctl: 3'd0, rd1: 19'd0, rd2: 19'd0,
          imm: 19'd0, pc: 15'd0, rd: 5'd0, cant_byte: 1'b0, fwd_a: 2'd0, fwd_b: 2'd0,
          result_w: 19'd0, stall: 1'b0, flush: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst        = ($urandom_range(0, 39) != 0);
    s.reg_write  = 1'($urandom);
    s.mem_write  = 1'($urandom);
    s.jump       = ($urandom_range(0, 5) == 0);
    s.alu_src    = 1'($urandom);
    s.branch     = 2'($urandom);
    s.result_src = 1'($urandom);
    s.alu_ctl    = 3'($urandom);
    s.rd1        = 19'($urandom);
    s.rd2        = ($urandom_range(0, 3) == 0) ? s.rd1 : 19'($urandom);
    s.imm        = ($urandom_range(0, 1) == 0) ? 19'($urandom_range(0, 40)) : 19'($urandom);
    s.pc         = 15'($urandom);
    s.rd         = 5'($urandom);
    s.cant_byte  = 1'($urandom);
    s.fwd_a      = 2'($urandom);
    s.fwd_b      = 2'($urandom);
    s.result_w   = 19'($urandom);
    s.stall      = ($urandom_range(0, 6) == 0);
    s.flush      = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one EX-stage cycle and record what the model says must come out.
  task automatic applyStimulus(input stim_t s);
    logic [18:0] a, fb, b;
    logic        taken;
    comb_t       c;
    mstate_t     nxt;
    @(negedge clk);
    reset = s.rst; RegWriteE = s.reg_write; MemWriteE = s.mem_write; JumpE = s.jump;
    ALUSrcE = s.alu_src; BranchE = s.branch; ResultSrcE = s.result_src;
    ALUControlE = s.alu_ctl; RD1E = s.rd1; RD2E = s.rd2; ImmExtE = s.imm; PCE = s.pc;
    RDE = s.rd; Cant_ByteE = s.cant_byte; ForwardAE = s.fwd_a; ForwardBE = s.fwd_b;
    ResultW = s.result_w; StallM = s.stall; FlushE = s.flush;
    if (!s.rst) model_m = '{default: '0};
    a  = pick(s.fwd_a, s.rd1, s.result_w, model_m.alu_result);
    fb = pick(s.fwd_b, s.rd2, s.result_w, model_m.alu_result);
    b  = s.alu_src ? s.imm : fb;
    case (s.branch)
      2'd1:    taken = (a == fb);
      2'd2:    taken = (a != fb);
      2'd3:    taken = (to_signed_val(a) < to_signed_val(fb));
      default: taken = 1'b0;
    endcase
    c.pcsrc  = !s.flush && (s.jump || taken);
    c.target = 15'((longint'(s.pc) + longint'(s.imm) % PC_MOD) % PC_MOD);
    comb_q.push_back(c);
    if (!s.rst || (!s.stall && s.flush)) nxt = '{default: '0};
    else if (s.stall) nxt = model_m;
    else nxt = '{reg_write: s.reg_write, mem_write: s.mem_write, result_src: s.result_src,
                 cant_byte: s.cant_byte, alu_result: model_alu(s.alu_ctl, a, b),
                 write_data: fb, rd: s.rd};
    reg_q.push_back(nxt);
    model_m = nxt;
  endtask

  // Monitor: combinational outputs just before the edge, registered ones just after.
  initial begin : monitor
    comb_t   c;
    mstate_t e;
    forever begin
      @(negedge clk);
      #3;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        checkOutput("PCSrcE", 32'(PCSrcE), 32'(c.pcsrc));
        if (c.pcsrc) checkOutput("PCTargetE", 32'(PCTargetE), 32'(c.target));
      end
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        checkOutput("RegWriteM",  32'(RegWriteM),  32'(e.reg_write));
        checkOutput("MemWriteM",  32'(MemWriteM),  32'(e.mem_write));
        checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(e.result_src));
        checkOutput("Cant_ByteM", 32'(Cant_ByteM), 32'(e.cant_byte));
        checkOutput("ALUResultM", 32'(ALUResultM), 32'(e.alu_result));
        checkOutput("WriteDataM", 32'(WriteDataM), 32'(e.write_data));
        checkOutput("RdM",        32'(RdM),        32'(e.rd));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    stim_t s;
    model_m = '{default: '0};
    reset = 1'b0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; ALUSrcE = 0; BranchE = 0;
    ResultSrcE = 0; ALUControlE = 0; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; RDE = 0;
    Cant_ByteE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0; StallM = 0; FlushE = 0;

    for (int i = 0; i < 4; i++) begin
      s = rand_stim();
      s.rst = 1'b0;
      applyStimulus(s);
    end
    s = rand_stim();
    s.rst = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
    applyStimulus(s);

    s = nop_stim();
    s.rd1 = 19'h7FFFF; s.rd2 = 19'd1; s.reg_write = 1'b1; s.rd = 5'd3;
    applyStimulus(s);
    s.alu_ctl = 3'b111;
    applyStimulus(s);

    s = nop_stim();
    s.rd1 = 19'd2; s.rd2 = 19'd3; s.reg_write = 1'b1; s.rd = 5'd5;
    applyStimulus(s);
    s.fwd_a = 2'b10; s.fwd_b = 2'b01; s.result_w = 19'd3; s.alu_ctl = 3'b001;
    applyStimulus(s);
    s = nop_stim();
    s.rd1 = 19'd2; s.rd2 = 19'd3; s.reg_write = 1'b1; s.rd = 5'd5;
    applyStimulus(s);
    s.fwd_a = 2'b10; s.fwd_b = 2'b01; s.result_w = 19'd3; s.alu_ctl = 3'b001;
    s.alu_src = 1'b1; s.imm = 19'd7; s.mem_write = 1'b1; s.cant_byte = 1'b1;
    applyStimulus(s);

    s = nop_stim();
    s.branch = 2'b11; s.rd1 = 19'h40000; s.rd2 = 19'd0; s.pc = 15'h7FFE; s.imm = 19'd4;
    s.reg_write = 1'b1; s.rd = 5'd9;
    applyStimulus(s);
    s.flush = 1'b1;
    applyStimulus(s);

    s = nop_stim();
    s.rd1 = 19'h1234; s.rd2 = 19'h55; s.alu_ctl = 3'b011; s.reg_write = 1'b1;
    s.result_src = 1'b1; s.rd = 5'd17;
    applyStimulus(s);
    s = rand_stim();
    s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
    applyStimulus(s);
    s.stall = 1'b0;
    applyStimulus(s);

    for (int i = 0; i < 400; i++) applyStimulus(rand_stim());

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drain", 32'(comb_q.size() + reg_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
